// File: rtl/piece_move_sequencer.sv
// Piece motion sequencer: latches move/gravity pulses, arbitrates them onto the
// shared collision-check port, and owns the spawn/fall/lock/game-over FSM.
module piece_move_sequencer #(
    parameter int GRID_W  = 10,
    parameter int GRID_H  = 20,
    parameter int SPAWN_X = 4,
    parameter int SPAWN_Y = 0
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       left_final,
    input  logic       right_final,
    input  logic       rot_final,
    input  logic       tick_gravity,
    output logic       chk_req,
    output logic [4:0] chk_x,
    output logic [4:0] chk_y,
    output logic [1:0] chk_rot,
    input  logic       chk_done,
    input  logic       chk_collide,
    output logic       lock_req,
    input  logic       lock_done,
    output logic [4:0] piece_x,
    output logic [4:0] piece_y,
    output logic [1:0] rot,
    output logic       move_accept,
    output logic       move_reject,
    output logic       game_over,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SPAWN = 4'd1,
        S_FALL  = 4'd2,
        S_LOCK  = 4'd3,
        S_CHECK = 4'd4,
        S_OVER  = 4'd5
    } state_t;

    typedef enum logic [2:0] {K_SPAWN, K_DOWN, K_ROT, K_LEFT, K_RIGHT} kind_t;

    localparam logic [4:0] X_MAX   = 5'(GRID_W - 1);
    localparam logic [4:0] Y_MAX   = 5'(GRID_H - 1);
    localparam logic [4:0] SPAWN_XV = 5'(SPAWN_X);
    localparam logic [4:0] SPAWN_YV = 5'(SPAWN_Y);

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic [3:0] pend_q, pend_d;   // {gravity, rot, left, right}
    logic [3:0] set_v, clr_v;
    logic       chk_req_q, chk_req_d;
    logic [4:0] chk_x_q, chk_x_d, chk_y_q, chk_y_d;
    logic [1:0] chk_rot_q, chk_rot_d;
    logic [4:0] piece_x_q, piece_x_d, piece_y_q, piece_y_d;
    logic [1:0] rot_q, rot_d;
    logic       lock_req_q, lock_req_d;
    logic       move_accept_q, move_accept_d;
    logic       move_reject_q, move_reject_d;
    logic       game_over_q, game_over_d;

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        chk_req_d     = 1'b0;
        chk_x_d       = chk_x_q;
        chk_y_d       = chk_y_q;
        chk_rot_d     = chk_rot_q;
        piece_x_d     = piece_x_q;
        piece_y_d     = piece_y_q;
        rot_d         = rot_q;
        lock_req_d    = 1'b0;
        move_accept_d = 1'b0;
        move_reject_d = 1'b0;
        game_over_d   = game_over_q;
        clr_v         = '0;
        set_v         = (state_q == S_FALL || state_q == S_CHECK) ?
                        {tick_gravity, rot_final, left_final, right_final} : '0;

        case (state_q)
            S_IDLE: if (start) state_d = S_SPAWN;
            S_SPAWN: begin
                chk_x_d   = SPAWN_XV;
                chk_y_d   = SPAWN_YV;
                chk_rot_d = 2'd0;
                kind_d    = K_SPAWN;
                chk_req_d = 1'b1;
                state_d   = S_CHECK;
            end
            S_FALL: begin
                // Bounds are resolved locally so no out-of-grid trial reaches the checker
                if (pend_q[3]) begin
                    clr_v = 4'b1000;
                    if (piece_y_q == Y_MAX) begin
                        lock_req_d = 1'b1;
                        state_d    = S_LOCK;
                    end else begin
                        {chk_x_d, chk_y_d, chk_rot_d} = {piece_x_q, piece_y_q + 5'd1, rot_q};
                        kind_d    = K_DOWN;
                        chk_req_d = 1'b1;
                        state_d   = S_CHECK;
                    end
                end else if (pend_q[2]) begin
                    clr_v = 4'b0100;
                    {chk_x_d, chk_y_d, chk_rot_d} = {piece_x_q, piece_y_q, rot_q + 2'd1};
                    kind_d    = K_ROT;
                    chk_req_d = 1'b1;
                    state_d   = S_CHECK;
                end else if (pend_q[1]) begin
                    clr_v = 4'b0010;
                    if (piece_x_q == 5'd0) begin
                        move_reject_d = 1'b1;
                    end else begin
                        {chk_x_d, chk_y_d, chk_rot_d} = {piece_x_q - 5'd1, piece_y_q, rot_q};
                        kind_d    = K_LEFT;
                        chk_req_d = 1'b1;
                        state_d   = S_CHECK;
                    end
                end else if (pend_q[0]) begin
                    clr_v = 4'b0001;
                    if (piece_x_q == X_MAX) begin
                        move_reject_d = 1'b1;
                    end else begin
                        {chk_x_d, chk_y_d, chk_rot_d} = {piece_x_q + 5'd1, piece_y_q, rot_q};
                        kind_d    = K_RIGHT;
                        chk_req_d = 1'b1;
                        state_d   = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                chk_req_d = 1'b1;
                if (chk_done) begin
                    chk_req_d = 1'b0;
                    if (!chk_collide) begin
                        piece_x_d     = chk_x_q;
                        piece_y_d     = chk_y_q;
                        rot_d         = chk_rot_q;
                        move_accept_d = (kind_q != K_SPAWN);
                        state_d       = S_FALL;
                    end else if (kind_q == K_SPAWN) begin
                        game_over_d = 1'b1;
                        state_d     = S_OVER;
                    end else if (kind_q == K_DOWN) begin
                        lock_req_d = 1'b1;
                        state_d    = S_LOCK;
                    end else begin
                        move_reject_d = 1'b1;
                        state_d       = S_FALL;
                    end
                end
            end
            S_LOCK: if (lock_done) state_d = S_SPAWN;
            S_OVER: game_over_d = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // A pulse arriving in its own grant cycle survives the clear
        pend_d = (pend_q & ~clr_v) | set_v;
        if (state_d == S_SPAWN) pend_d = '0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= S_IDLE;
            kind_q        <= K_SPAWN;
            pend_q        <= '0;
            chk_req_q     <= 1'b0;
            chk_x_q       <= '0;
            chk_y_q       <= '0;
            chk_rot_q     <= '0;
            piece_x_q     <= SPAWN_XV;
            piece_y_q     <= SPAWN_YV;
            rot_q         <= '0;
            lock_req_q    <= 1'b0;
            move_accept_q <= 1'b0;
            move_reject_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            pend_q        <= pend_d;
            chk_req_q     <= chk_req_d;
            chk_x_q       <= chk_x_d;
            chk_y_q       <= chk_y_d;
            chk_rot_q     <= chk_rot_d;
            piece_x_q     <= piece_x_d;
            piece_y_q     <= piece_y_d;
            rot_q         <= rot_d;
            lock_req_q    <= lock_req_d;
            move_accept_q <= move_accept_d;
            move_reject_q <= move_reject_d;
            game_over_q   <= game_over_d;
        end
    end

    assign state       = state_q;
    assign chk_req     = chk_req_q;
    assign chk_x       = chk_x_q;
    assign chk_y       = chk_y_q;
    assign chk_rot     = chk_rot_q;
    assign piece_x     = piece_x_q;
    assign piece_y     = piece_y_q;
    assign rot         = rot_q;
    assign lock_req    = lock_req_q;
    assign move_accept = move_accept_q;
    assign move_reject = move_reject_q;
    assign game_over   = game_over_q;
endmodule

// File: tb/tb_piece_move_sequencer.sv
// Directed bench for piece_move_sequencer: per-cycle vector table plus
// hand-written sequences for gravity runs, edge rejects, floor lock and reset.
module tb_piece_move_sequencer;
    logic       clk = 1'b0;
    logic       reset, start, left_final, right_final, rot_final, tick_gravity;
    logic       chk_done, chk_collide, lock_done;
    logic       chk_req, lock_req, move_accept, move_reject, game_over;
    logic [4:0] chk_x, chk_y, piece_x, piece_y;
    logic [1:0] chk_rot, rot;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int req_cnt = 0;

    always #5 clk = ~clk;

    piece_move_sequencer #(.GRID_W(10), .GRID_H(20), .SPAWN_X(4), .SPAWN_Y(0)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start),
        .left_final(left_final), .right_final(right_final), .rot_final(rot_final),
        .tick_gravity(tick_gravity),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_rot(chk_rot),
        .chk_done(chk_done), .chk_collide(chk_collide),
        .lock_req(lock_req), .lock_done(lock_done),
        .piece_x(piece_x), .piece_y(piece_y), .rot(rot),
        .move_accept(move_accept), .move_reject(move_reject),
        .game_over(game_over), .state(state)
    );

    always @(negedge clk) begin
        if (move_accept === 1'b1) acc_cnt++;
        if (chk_req === 1'b1) req_cnt++;
    end

    typedef struct {
        logic [8:0] in;   // {rst, start, grav, rot, left, right, chk_done, collide, lock_done}
        int es, ereq, ecx, ecy, ecr, epx, epy, epr, eacc, erej, elk, ego;
    } vec_t;
    vec_t tv[$];

    task automatic v(input logic [8:0] in, input int es, ereq, ecx, ecy, ecr,
                     input int epx, epy, epr, eacc, erej, elk, ego);
        vec_t r;
        r.in = in; r.es = es; r.ereq = ereq; r.ecx = ecx; r.ecy = ecy; r.ecr = ecr;
        r.epx = epx; r.epy = epy; r.epr = epr; r.eacc = eacc; r.erej = erej;
        r.elk = elk; r.ego = ego;
        tv.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        {reset, start, tick_gravity, rot_final, left_final, right_final} = '0;
        {chk_done, chk_collide, lock_done} = '0;
    endtask

    // p = {grav, rot, left, right}, held for one clock
    task automatic pulse(input logic [3:0] p);
        {tick_gravity, rot_final, left_final, right_final} = p;
        cyc();
        {tick_gravity, rot_final, left_final, right_final} = '0;
    endtask

    task automatic serve(input string tag, input logic coll, input int ex, ey, er);
        int n = 0;
        while (chk_req !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        chk({tag, "_req_seen"}, chk_req, 1);
        chk({tag, "_chk_x"}, chk_x, ex);
        chk({tag, "_chk_y"}, chk_y, ey);
        chk({tag, "_chk_rot"}, chk_rot, er);
        chk_done = 1'b1;
        chk_collide = coll;
        cyc();
        chk_done = 1'b0;
        chk_collide = 1'b0;
        chk({tag, "_req_drop"}, chk_req, 0);
    endtask

    task automatic edge_reject(input string tag, input logic [3:0] p, input int ex);
        int r0;
        r0 = req_cnt;
        pulse(p);
        cyc();
        chk({tag, "_reject"}, move_reject, 1);
        chk({tag, "_state"}, state, 2);
        cyc();
        chk({tag, "_reject_1cyc"}, move_reject, 0);
        chk({tag, "_no_req"}, 32'(req_cnt - r0), 0);
        chk({tag, "_x"}, piece_x, ex);
    endtask

    initial begin
        int a0;
        clr_in();

        // in bits: rst st g ro l r cd cc ld
        v(9'b1_0_0_0_0_0_0_0_0, 0,0,0,0,0, 4,0,0, 0,0,0,0);
        v(9'b0_1_0_0_0_0_0_0_0, 1,0,0,0,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,4,0,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_0_0, 2,0,4,0,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_1_0_0_0_0_0_0, 2,0,4,0,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,4,1,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_0_0, 2,0,4,1,0, 4,1,0, 1,0,0,0);
        v(9'b0_0_0_0_1_0_0_0_0, 2,0,4,1,0, 4,1,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,3,1,0, 4,1,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_1_0, 2,0,3,1,0, 4,1,0, 0,1,0,0);
        v(9'b0_0_0_0_0_1_0_0_0, 2,0,3,1,0, 4,1,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,5,1,0, 4,1,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_0_0, 2,0,5,1,0, 5,1,0, 1,0,0,0);
        v(9'b0_0_1_1_1_1_0_0_0, 2,0,5,1,0, 5,1,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,5,2,0, 5,1,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_0_0, 2,0,5,2,0, 5,2,0, 1,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,5,2,1, 5,2,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_0_0, 2,0,5,2,1, 5,2,1, 1,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,4,2,1, 5,2,1, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_0_0, 2,0,4,2,1, 4,2,1, 1,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,5,2,1, 4,2,1, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_0_0, 2,0,5,2,1, 5,2,1, 1,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 2,0,5,2,1, 5,2,1, 0,0,0,0);
        v(9'b0_0_0_0_1_0_0_0_0, 2,0,5,2,1, 5,2,1, 0,0,0,0);
        v(9'b0_0_0_0_1_0_0_0_0, 4,1,4,2,1, 5,2,1, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_0_0, 2,0,4,2,1, 4,2,1, 1,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,3,2,1, 4,2,1, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_0_0, 2,0,3,2,1, 3,2,1, 1,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 2,0,3,2,1, 3,2,1, 0,0,0,0);
        v(9'b0_0_1_0_0_0_0_0_0, 2,0,3,2,1, 3,2,1, 0,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,3,3,1, 3,2,1, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_1_0, 3,0,3,3,1, 3,2,1, 0,0,1,0);
        v(9'b0_0_0_0_1_0_0_0_0, 3,0,3,3,1, 3,2,1, 0,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_1, 1,0,3,3,1, 3,2,1, 0,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,4,0,0, 3,2,1, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_0_0, 2,0,4,0,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_1_0, 2,0,4,0,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_1_0_0_0_0_0_0, 2,0,4,0,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,4,1,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_1_0, 3,0,4,1,0, 4,0,0, 0,0,1,0);
        v(9'b0_0_0_0_0_0_0_0_1, 1,0,4,1,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_0_0_0, 4,1,4,0,0, 4,0,0, 0,0,0,0);
        v(9'b0_0_0_0_0_0_1_1_0, 5,0,4,0,0, 4,0,0, 0,0,0,1);
        v(9'b0_0_1_0_0_0_0_0_0, 5,0,4,0,0, 4,0,0, 0,0,0,1);
        v(9'b0_1_0_0_0_0_0_0_0, 5,0,4,0,0, 4,0,0, 0,0,0,1);
        v(9'b1_0_0_0_0_0_0_0_0, 0,0,0,0,0, 4,0,0, 0,0,0,0);

        for (int i = 0; i < tv.size(); i++) begin
            {reset, start, tick_gravity, rot_final, left_final, right_final,
             chk_done, chk_collide, lock_done} = tv[i].in;
            cyc();
            chk($sformatf("row%0d_state", i),   state,       tv[i].es);
            chk($sformatf("row%0d_chk_req", i), chk_req,     tv[i].ereq);
            chk($sformatf("row%0d_chk_x", i),   chk_x,       tv[i].ecx);
            chk($sformatf("row%0d_chk_y", i),   chk_y,       tv[i].ecy);
            chk($sformatf("row%0d_chk_rot", i), chk_rot,     tv[i].ecr);
            chk($sformatf("row%0d_piece_x", i), piece_x,     tv[i].epx);
            chk($sformatf("row%0d_piece_y", i), piece_y,     tv[i].epy);
            chk($sformatf("row%0d_rot", i),     rot,         tv[i].epr);
            chk($sformatf("row%0d_accept", i),  move_accept, tv[i].eacc);
            chk($sformatf("row%0d_reject", i),  move_reject, tv[i].erej);
            chk($sformatf("row%0d_lock_req", i), lock_req,   tv[i].elk);
            chk($sformatf("row%0d_game_over", i), game_over, tv[i].ego);
        end
        clr_in();

        // Spawn, then eight spaced gravity drops
        reset = 1'b1; cyc(); reset = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        a0 = acc_cnt;
        serve("spawn", 1'b0, 4, 0, 0);
        cyc();
        chk("spawn_no_accept", 32'(acc_cnt - a0), 0);
        chk("spawn_state", state, 2);
        for (int i = 1; i <= 8; i++) begin
            pulse(4'b1000);
            serve($sformatf("grav%0d", i), 1'b0, 4, i, 0);
            chk($sformatf("grav%0d_piece_y", i), piece_y, i);
            repeat (50) cyc();
        end
        chk("grav_accept_count", 32'(acc_cnt - a0), 8);

        pulse(4'b0010);
        serve("left1", 1'b0, 3, 8, 0);
        chk("left1_piece_x", piece_x, 3);
        pulse(4'b0100);
        serve("rot1", 1'b0, 3, 8, 1);
        chk("rot1_rot", rot, 1);
        for (int k = 2; k <= 5; k++) begin
            pulse(4'b0100);
            serve($sformatf("rotw%0d", k), 1'b0, 3, 8, k % 4);
            chk($sformatf("rotw%0d_rot", k), rot, k % 4);
        end

        for (int x = 2; x >= 0; x--) begin
            pulse(4'b0010);
            serve($sformatf("toleft%0d", x), 1'b0, x, 8, 1);
        end
        for (int k = 0; k < 3; k++) edge_reject($sformatf("lwall%0d", k), 4'b0010, 0);

        for (int x = 1; x <= 9; x++) begin
            pulse(4'b0001);
            serve($sformatf("toright%0d", x), 1'b0, x, 8, 1);
        end
        edge_reject("rwall", 4'b0001, 9);

        // Drop to the floor; gravity on the last row locks without a check
        for (int y = 9; y <= 19; y++) begin
            pulse(4'b1000);
            serve($sformatf("drop%0d", y), 1'b0, 9, y, 1);
        end
        a0 = req_cnt;
        pulse(4'b1000);
        cyc();
        chk("floor_lock_req", lock_req, 1);
        chk("floor_state", state, 3);
        chk("floor_piece_y", piece_y, 19);
        cyc();
        chk("floor_lock_1cyc", lock_req, 0);
        chk("floor_no_req", 32'(req_cnt - a0), 0);

        // Late chk_done on spawn, then reset while a check is outstanding
        lock_done = 1'b1; cyc(); lock_done = 1'b0;
        chk("relock_spawn", state, 1);
        cyc();
        repeat (3) begin
            cyc();
            chk("late_req_held", chk_req, 1);
            chk("late_chk_x", chk_x, 4);
        end
        serve("late", 1'b0, 4, 0, 0);
        chk("late_piece", {piece_x, piece_y, rot}, (4 << 7));
        pulse(4'b1000);
        cyc();
        chk("midchk_req", chk_req, 1);
        reset = 1'b1; chk_done = 1'b1;
        cyc();
        reset = 1'b0; chk_done = 1'b0;
        chk("midrst_req", chk_req, 0);
        chk("midrst_state", state, 0);
        chk("midrst_chk_y", chk_y, 0);
        chk("midrst_piece_y", piece_y, 0);
        chk("midrst_piece_x", piece_x, 4);
        chk("midrst_accept", move_accept, 0);
        cyc();
        chk("midrst_accept_after", move_accept, 0);
        chk("midrst_idle", state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
